// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared sizes, write-select codes and one-hot helper for regfile_4x8
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

   localparam int NUM_ENTRIES = 4;
   localparam int ADDR_W      = 2;

   typedef logic [NUM_ENTRIES-1:0] wr_sel_t;
   typedef logic [ADDR_W-1:0]      addr_t;

   localparam wr_sel_t SEL_NONE = 4'b0000;
   localparam wr_sel_t SEL_E0   = 4'b0001;
   localparam wr_sel_t SEL_E1   = 4'b0010;
   localparam wr_sel_t SEL_E2   = 4'b0100;
   localparam wr_sel_t SEL_E3   = 4'b1000;

   // Indexed by entry number so generate loops can pick the matching code.
   localparam logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] SEL_ONEHOT =
      {SEL_E3, SEL_E2, SEL_E1, SEL_E0};

   function automatic logic is_onehot4(input wr_sel_t sel);
      return (sel != SEL_NONE) && ((sel & (sel - 4'd1)) == SEL_NONE);
   endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_entry.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_entry
//  Brief    : One data register plus valid bit; clear wins over write
//  Revision : 1.0  initial release
// ============================================================================
module regfile_entry #(
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic          i_clr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_data,
   output logic          o_valid
);

   logic [DW-1:0] r_data;
   logic          r_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_clr) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_we) begin
         r_data  <= i_wdata;
         r_valid <= 1'b1;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule : regfile_entry
`default_nettype wire

// File: rtl/regfile_4x8.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_4x8
//  Brief    : 4-entry register bank, one-hot write select, 1-cycle registered
//             read with write/clear bypass and illegal-select counter
//  Revision : 1.0  initial release
// ============================================================================
module regfile_4x8
   import regfile_pkg::*;
#(
   parameter int DW        = 8,
   parameter int ERR_CNT_W = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [3:0]           i_wr_sel,
   input  logic [DW-1:0]        i_wdata,
   input  logic                 i_clr,
   input  logic                 i_rd_en,
   input  logic [1:0]           i_rd_addr,
   output logic [DW-1:0]        o_rdata,
   output logic                 o_rd_valid,
   output logic                 o_rd_hit,
   output logic [3:0]           o_entry_valid,
   output logic                 o_wr_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

   logic                   w_sel_legal;
   logic                   w_sel_multi;
   logic [NUM_ENTRIES-1:0] w_wr_en;
   logic [NUM_ENTRIES-1:0] w_entry_valid;
   logic [DW-1:0]          w_entry_data [NUM_ENTRIES];
   logic [DW-1:0]          w_rd_data;
   logic                   w_rd_hit;

   logic [DW-1:0]          r_rdata;
   logic                   r_rd_valid;
   logic                   r_rd_hit;
   logic                   r_wr_err;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   assign w_sel_legal = is_onehot4(i_wr_sel);
   assign w_sel_multi = (i_wr_sel != SEL_NONE) && !w_sel_legal;

   generate
      for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
         assign w_wr_en[k] = (i_wr_sel == SEL_ONEHOT[k]);

         regfile_entry #(
            .DW (DW)
         ) u_entry (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (w_wr_en[k]),
            .i_clr   (i_clr),
            .i_wdata (i_wdata),
            .o_data  (w_entry_data[k]),
            .o_valid (w_entry_valid[k])
         );
      end
   endgenerate

   // Read data as it will be after this edge: clear first, then write-through.
   always_comb begin
      w_rd_data = '0;
      w_rd_hit  = 1'b0;
      if (!i_clr) begin
         if (w_wr_en[i_rd_addr]) begin
            w_rd_data = i_wdata;
            w_rd_hit  = 1'b1;
         end else if (w_entry_valid[i_rd_addr]) begin
            w_rd_data = w_entry_data[i_rd_addr];
            w_rd_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rdata  <= w_rd_data;
            r_rd_hit <= w_rd_hit;
         end
      end
   end

   // Error count survives i_clr; only reset brings it back to zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_err  <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_wr_err <= w_sel_multi;
         if (w_sel_multi && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign o_rdata       = r_rdata;
   assign o_rd_valid    = r_rd_valid;
   assign o_rd_hit      = r_rd_hit;
   assign o_entry_valid = w_entry_valid;
   assign o_wr_err      = r_wr_err;
   assign o_err_cnt     = r_err_cnt;

endmodule : regfile_4x8
`default_nettype wire

// File: tb/tb_regfile_4x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_4x8
//  Brief    : Directed table-driven bench for regfile_4x8
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_4x8;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [3:0] i_wr_sel;
   logic [7:0] i_wdata;
   logic       i_clr;
   logic       i_rd_en;
   logic [1:0] i_rd_addr;
   logic [7:0] o_rdata;
   logic       o_rd_valid;
   logic       o_rd_hit;
   logic [3:0] o_entry_valid;
   logic       o_wr_err;
   logic [3:0] o_err_cnt;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   regfile_4x8 #(
      .DW        (8),
      .ERR_CNT_W (4)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_wr_sel      (i_wr_sel),
      .i_wdata       (i_wdata),
      .i_clr         (i_clr),
      .i_rd_en       (i_rd_en),
      .i_rd_addr     (i_rd_addr),
      .o_rdata       (o_rdata),
      .o_rd_valid    (o_rd_valid),
      .o_rd_hit      (o_rd_hit),
      .o_entry_valid (o_entry_valid),
      .o_wr_err      (o_wr_err),
      .o_err_cnt     (o_err_cnt)
   );

   typedef struct {
      logic [3:0] wr_sel;
      logic [7:0] wdata;
      logic       clr;
      logic       rd_en;
      logic [1:0] rd_addr;
      logic       e_rv;
      logic [7:0] e_rdata;
      logic       e_hit;
      logic [3:0] e_ev;
      logic       e_err;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vecs [18];

   // Observed outputs packed as {rd_valid, rdata, rd_hit, entry_valid, wr_err, err_cnt}.
   function automatic logic [18:0] obs();
      return {o_rd_valid, o_rdata, o_rd_hit, o_entry_valid, o_wr_err, o_err_cnt};
   endfunction

   task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {rv,rdata,hit,ev,err,cnt}=%h required %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] sel, input logic [7:0] wd, input logic clr,
                        input logic rd, input logic [1:0] addr);
      i_wr_sel  = sel;
      i_wdata   = wd;
      i_clr     = clr;
      i_rd_en   = rd;
      i_rd_addr = addr;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //                wr_sel   wdata  clr   rd    addr   rv    rdata  hit   ev       err   cnt
      vecs[0]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd0};
      vecs[1]  = '{4'b0100, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b0, 4'd0};
      vecs[2]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA5, 1'b1, 4'b0100, 1'b0, 4'd0};
      vecs[3]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 4'b0100, 1'b0, 4'd0};
      vecs[4]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b0, 4'd0};
      vecs[5]  = '{4'b0011, 8'hFF, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b1, 4'd1};
      vecs[6]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b0, 4'd1};
      vecs[7]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA5, 1'b1, 4'b0100, 1'b0, 4'd1};
      vecs[8]  = '{4'b1000, 8'h11, 1'b0, 1'b0, 2'd0, 1'b0, 8'hA5, 1'b1, 4'b1100, 1'b0, 4'd1};
      vecs[9]  = '{4'b1000, 8'h22, 1'b0, 1'b1, 2'd3, 1'b1, 8'h22, 1'b1, 4'b1100, 1'b0, 4'd1};
      vecs[10] = '{4'b0000, 8'h00, 1'b1, 1'b1, 2'd3, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd1};
      vecs[11] = '{4'b0001, 8'h5A, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd1};
      vecs[12] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd1};
      vecs[13] = '{4'b0001, 8'h5A, 1'b0, 1'b1, 2'd0, 1'b1, 8'h5A, 1'b1, 4'b0001, 1'b0, 4'd1};
      vecs[14] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 8'h5A, 1'b1, 4'b0001, 1'b0, 4'd1};
      vecs[15] = '{4'b1111, 8'hEE, 1'b1, 1'b0, 2'd0, 1'b0, 8'h5A, 1'b1, 4'b0000, 1'b1, 4'd2};
      vecs[16] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd2};
      vecs[17] = '{4'b0110, 8'h33, 1'b0, 1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 4'b0000, 1'b1, 4'd3};

      i_rst_n = 1'b0;
      drive(4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
      step();
      step();
      check("reset_state", obs(), 19'h0);
      i_rst_n = 1'b1;

      for (int v = 0; v < 18; v++) begin
         drive(vecs[v].wr_sel, vecs[v].wdata, vecs[v].clr, vecs[v].rd_en, vecs[v].rd_addr);
         step();
         check($sformatf("vec%0d", v), obs(),
               {vecs[v].e_rv, vecs[v].e_rdata, vecs[v].e_hit, vecs[v].e_ev,
                vecs[v].e_err, vecs[v].e_cnt});
      end

      // Saturation: counter is 3 here; 20 more illegal selects pin it at 15.
      for (int i = 0; i < 20; i++) begin
         drive(4'b1010, 8'hFF, 1'b0, 1'b0, 2'd0);
         step();
         check($sformatf("sat%0d", i), obs(),
               {1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 4'((i + 4 > 15) ? 15 : i + 4)});
      end
      drive(4'b0000, 8'h00, 1'b1, 1'b0, 2'd0);
      step();
      check("sat_after_clr", obs(), {1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd15});

      // Fill all entries, then reset while a read result is showing and another is pending.
      for (int k = 0; k < 4; k++) begin
         drive(4'(1 << k), 8'(8'h10 + k), 1'b0, 1'b0, 2'd0);
         step();
      end
      drive(4'b0000, 8'h00, 1'b0, 1'b1, 2'd2);
      step();
      check("fill_read", obs(), {1'b1, 8'h12, 1'b1, 4'b1111, 1'b0, 4'd15});
      drive(4'b0000, 8'h00, 1'b0, 1'b1, 2'd3);
      #3;
      i_rst_n = 1'b0;
      #1;
      check("async_reset", obs(), 19'h0);
      drive(4'b0000, 8'h00, 1'b0, 1'b0, 2'd0);
      step();
      i_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_reset%0d", i), obs(), 19'h0);
      end
      drive(4'b0000, 8'h00, 1'b0, 1'b1, 2'd3);
      step();
      check("post_reset_read", obs(), {1'b1, 8'h00, 1'b0, 4'b0000, 1'b0, 4'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_4x8
`default_nettype wire
